// File: rtl/fp_add_stream_ctrl.sv
// fp_add_stream_ctrl: issues (a, b) operand pairs one at a time to a
// single-issue float32 adder core using a load/busy handshake.
// Results are queued in a first-word-fall-through FIFO.
// A busy watchdog replaces a hung operation with a canonical qNaN.
module fp_add_stream_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_load,
    input  logic             add_busy,
    input  logic [31:0]      add_sum,
    input  logic             add_status,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_status,
    output logic             err_timeout,
    output logic [CNT_W-1:0] ops_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic              load_q, load_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  ops_q, ops_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [32:0]       mem_q [DEPTH];

    logic              accept;
    logic              pop;
    logic              push;
    logic [32:0]       push_word;

    // Acceptance uses the registered count only, so a pop in the same cycle
    // cannot open the input early.
    assign in_ready    = !reset && (state_q == S_IDLE) && (count_q < CW'(DEPTH));
    assign accept      = in_valid && in_ready;
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid && out_ready;
    assign out_sum     = mem_q[rd_ptr_q][32:1];
    assign out_status  = mem_q[rd_ptr_q][0];
    assign add_a       = a_q;
    assign add_b       = b_q;
    assign add_load    = load_q;
    assign err_timeout = err_q;
    assign ops_done    = ops_q;

    // Next-state logic for the sequencer, watchdog and FIFO bookkeeping.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        load_d    = 1'b0;
        err_d     = err_q;
        tmo_d     = '0;
        push      = 1'b0;
        push_word = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    load_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // Busy is not trusted yet: the core needs this cycle to raise it.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!add_busy) begin
                    push      = 1'b1;
                    push_word = {add_sum, add_status};
                    state_d   = S_IDLE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    push      = 1'b1;
                    push_word = {QNAN, 1'b1};
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        ops_d    = push ? ops_q + CNT_W'(1) : ops_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            load_q   <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
            ops_q    <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            load_q   <= load_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
            ops_q    <= ops_d;
            tmo_q    <= tmo_d;
        end
    end

    // Result storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

endmodule

// File: tb/tb_fp_add_stream_ctrl.sv
// Directed testbench for fp_add_stream_ctrl with a small behavioural adder core.
module tb_fp_add_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic [31:0] add_a, add_b;
    logic        add_load;
    logic        add_busy;
    logic [31:0] add_sum;
    logic        add_status;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_status;
    logic        err_timeout;
    logic [15:0] ops_done;

    int n_cmp = 0;
    int n_bad = 0;

    // Core model controls.
    int          core_lat      = 0;
    bit          core_stuck    = 1'b0;
    bit          core_fixed_en = 1'b0;
    logic [31:0] core_fixed    = '0;
    logic        core_fixed_st = 1'b0;
    int          core_cnt;

    always #5 clk = ~clk;

    fp_add_stream_ctrl #(.DEPTH(4), .TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_load(add_load), .add_busy(add_busy),
        .add_sum(add_sum), .add_status(add_status),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_status(out_status), .err_timeout(err_timeout), .ops_done(ops_done)
    );

    // Behavioural adder core: busy for core_lat cycles after load.
    // The sum is either a fixed value or a ^ b, and the status is a[0].
    always @(posedge clk) begin
        if (reset) begin
            add_busy   <= 1'b0;
            add_sum    <= '0;
            add_status <= 1'b0;
            core_cnt   <= 0;
        end else if (add_load) begin
            add_busy   <= core_stuck || (core_lat != 0);
            core_cnt   <= core_lat;
            add_sum    <= core_fixed_en ? core_fixed : (add_a ^ add_b);
            add_status <= core_fixed_en ? core_fixed_st : add_a[0];
        end else if (add_busy && !core_stuck) begin
            if (core_cnt <= 1) add_busy <= 1'b0;
            core_cnt <= core_cnt - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) chk("send_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        $display("issue a=%h b=%h", a, b);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] s, input logic st);
        int c;
        wait_out(c);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_sum"}, out_sum, s);
        chk({tag, "_status"}, {31'b0, out_status}, {31'b0, st});
        $display("result sum=%h status=%0d", out_sum, out_status);
        pop();
    endtask

    initial begin
        int c, accepted, i, j, cyc;
        bit seen, hs;
        int hsq[$];

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_add_load", {31'b0, add_load}, 32'd0);
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_err", {31'b0, err_timeout}, 32'd0);
        chk("rst_ops", {16'b0, ops_done}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

        // Single op, core busy 5 cycles
        core_lat = 5; core_fixed_en = 1'b1; core_fixed = 32'h4040_0000; core_fixed_st = 1'b0;
        send(32'h3F80_0000, 32'h4000_0000);
        chk("single_load_hi", {31'b0, add_load}, 32'd1);
        chk("single_add_a", add_a, 32'h3F80_0000);
        chk("single_add_b", add_b, 32'h4000_0000);
        chk("single_busy_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("single_load_lo", {31'b0, add_load}, 32'd0);
        wait_out(c);
        chk("single_latency", c, 32'd6);
        chk("single_sum", out_sum, 32'h4040_0000);
        chk("single_status", {31'b0, out_status}, 32'd0);
        chk("single_ops", {16'b0, ops_done}, 32'd1);
        $display("result sum=%h status=%0d", out_sum, out_status);
        pop();
        chk("single_drained", {31'b0, out_valid}, 32'd0);

        // Zero-wait core
        core_lat = 0; core_fixed_en = 1'b0;
        send(32'd1, 32'd2);
        wait_out(c);
        chk("zw_latency", c, 32'd3);
        chk("zw_sum", out_sum, 32'd3);
        chk("zw_status", {31'b0, out_status}, 32'd1);
        pop();

        // Back-to-back issue interval
        out_ready = 1'b1; in_valid = 1'b1; in_a = 32'h100; in_b = 32'h0;
        for (int idx = 0; idx < 12; idx++) begin
            if (in_ready) hsq.push_back(idx);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        out_ready = 1'b0;
        chk("b2b_count", hsq.size(), 32'd3);
        if (hsq.size() == 3) begin
            chk("b2b_hs0", hsq[0], 32'd0);
            chk("b2b_hs1", hsq[1], 32'd4);
            chk("b2b_hs2", hsq[2], 32'd8);
        end
        chk("b2b_ops", {16'b0, ops_done}, 32'd5);
        chk("b2b_empty", {31'b0, out_valid}, 32'd0);

        // Back-pressure: 6 pairs offered, FIFO of 4
        core_lat = 2; accepted = 0; i = 0;
        in_valid = 1'b1; in_a = 32'h10; in_b = 32'h100;
        for (int k = 0; k < 40; k++) begin
            if (in_valid && in_ready) begin
                tick();
                accepted++; i++;
                in_a = 32'h10 + i;
            end else begin
                tick();
            end
        end
        chk("bp_accepted", accepted, 32'd4);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1; j = 0; cyc = 0;
        while (j < 6 && cyc < 200) begin
            hs = in_valid && in_ready;
            if (out_valid) begin
                chk("bp_sum", out_sum, (32'h10 + j) ^ 32'h100);
                chk("bp_status", {31'b0, out_status}, j & 1);
                $display("result sum=%h status=%0d", out_sum, out_status);
                j++;
            end
            tick();
            cyc++;
            if (hs) begin
                i++;
                if (i >= 6) in_valid = 1'b0;
                else in_a = 32'h10 + i;
            end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("bp_drained", j, 32'd6);
        chk("bp_ops", {16'b0, ops_done}, 32'd11);

        // Watchdog timeout
        core_stuck = 1'b1;
        send(32'd5, 32'd6);
        wait_out(c);
        chk("tmo_latency", c, 32'd10);
        chk("tmo_sum", out_sum, 32'h7FC0_0000);
        chk("tmo_status", {31'b0, out_status}, 32'd1);
        chk("tmo_err", {31'b0, err_timeout}, 32'd1);
        chk("tmo_ops", {16'b0, ops_done}, 32'd12);
        pop();
        core_stuck = 1'b0; core_lat = 1;
        tick();
        send(32'd8, 32'd9);
        pop_expect("tmo_next", 32'd1, 1'b0);
        chk("tmo_err_sticky", {31'b0, err_timeout}, 32'd1);
        chk("tmo_next_ops", {16'b0, ops_done}, 32'd13);

        // Reset mid-operation
        core_lat = 10;
        send(32'd3, 32'd4);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("mid_in_ready", {31'b0, in_ready}, 32'd0);
        chk("mid_add_load", {31'b0, add_load}, 32'd0);
        chk("mid_add_a", add_a, 32'd0);
        chk("mid_add_b", add_b, 32'd0);
        chk("mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_err", {31'b0, err_timeout}, 32'd0);
        chk("mid_ops", {16'b0, ops_done}, 32'd0);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("mid_no_stale", {31'b0, seen}, 32'd0);
        chk("mid_in_ready_after", {31'b0, in_ready}, 32'd1);

        // Simultaneous push/pop across pointer wrap
        core_lat = 0;
        send(32'h30, 32'h0);
        pop_expect("pp_pre0", 32'h30, 1'b0);
        send(32'h31, 32'h0);
        pop_expect("pp_pre1", 32'h31, 1'b1);
        send(32'h40, 32'h0);
        send(32'h41, 32'h0);
        send(32'h42, 32'h0);
        send(32'h43, 32'h0);
        tick(); tick();
        chk("pp_head", out_sum, 32'h40);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pp_in_ready", {31'b0, in_ready}, 32'd1);
        chk("pp_ops", {16'b0, ops_done}, 32'd6);
        pop_expect("pp_e1", 32'h41, 1'b1);
        pop_expect("pp_e2", 32'h42, 1'b0);
        pop_expect("pp_e3", 32'h43, 1'b1);
        chk("pp_empty", {31'b0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
